// File: rtl/l1c_data_param.sv
// Set-associative write-through L1 data cache, flop-array storage; optional counters via L1C_PERF_CNT_EN.
// Latency: load hit 1 cycle after accept; load miss = lookup + line request + LINE_WORDS beats + resp.
// Backpressure: core_wait held while busy; D_wait stalls WRITE/MREQ; one request in flight.
module l1c_data_param #(
   parameter int SETS       = 32,
   parameter int LINE_WORDS = 4,
   parameter int WAYS       = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_req,
   input  logic [31:0] core_addr,
   input  logic        core_write,
   input  logic [3:0]  core_wstrb,
   input  logic [31:0] core_in,
   output logic [31:0] core_out,
   output logic        core_wait,
   output logic        D_req,
   output logic [31:0] D_addr,
   output logic        D_write,
   output logic [31:0] D_in,
   output logic [3:0]  D_type,
   input  logic        D_wait,
   input  logic        rvalid,
   input  logic [31:0] D_out
`ifdef L1C_PERF_CNT_EN
   ,
   output logic [31:0] perf_hit_cnt,
   output logic [31:0] perf_miss_cnt
`endif
);

   localparam int IDX_W = $clog2(SETS);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITE, MREQ, REFILL, RESP} state_t;

   state_t            state;
   logic [31:0]       req_addr;
   logic              req_write;
   logic [3:0]        req_wstrb;
   logic [31:0]       req_data;
   logic [OFF_W-1:0]  beat;
   logic [WAY_W-1:0]  victim;
   logic [31:0]       core_out_q;

   logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
   logic [31:0]       data_mem [WAYS][SETS][LINE_WORDS];
   logic [SETS-1:0]   valid    [WAYS];
   logic [WAY_W-1:0]  ptr      [SETS];
   logic [31:0]       line_buf [LINE_WORDS];

   logic [IDX_W-1:0]  idx;
   logic [OFF_W-1:0]  off;
   logic [TAG_W-1:0]  req_tag;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic [31:0]       hit_word;
   logic              inv_found;
   logic [WAY_W-1:0]  victim_sel;
   logic              last_beat;
   logic              load_hit;

   assign idx       = req_addr[OFF_W+IDX_W+1 -: IDX_W];
   assign off       = req_addr[OFF_W+1 -: OFF_W];
   assign req_tag   = req_addr[31 -: TAG_W];
   assign last_beat = (beat == OFF_W'(LINE_WORDS - 1));
   assign load_hit  = (state == LOOKUP) && !req_write && hit;

   always_comb begin
      hit        = 1'b0;
      hit_way    = '0;
      inv_found  = 1'b0;
      victim_sel = ptr[idx];
      for (int w = 0; w < WAYS; w++) begin
         if (valid[w][idx] && tag_mem[w][idx] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         // lowest-index invalid way wins over the round-robin pointer
         if (!inv_found && !valid[w][idx]) begin
            inv_found  = 1'b1;
            victim_sel = WAY_W'(w);
         end
      end
      hit_word = data_mem[hit_way][idx][off];
   end

   always_comb begin
      core_wait = 1'b1;
      case (state)
         IDLE:    core_wait = core_req;
         LOOKUP:  core_wait = !load_hit;
         WRITE:   core_wait = D_wait;
         RESP:    core_wait = 1'b0;
         default: core_wait = 1'b1;
      endcase
   end

   assign core_out = load_hit ? hit_word : core_out_q;
   assign D_req    = (state == WRITE) || (state == MREQ);
   assign D_write  = (state == WRITE);
   assign D_addr   = (state == WRITE) ? req_addr :
                     (state == MREQ)  ? {req_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}} : 32'h0;
   assign D_in     = (state == WRITE) ? req_data : 32'h0;
   assign D_type   = (state == WRITE) ? req_wstrb :
                     (state == MREQ)  ? 4'hF : 4'h0;

   // Storage arrays carry no reset; a line only becomes visible through its valid bit.
   always_ff @(posedge clk) begin
      if (state == LOOKUP && req_write && hit) begin
         for (int b = 0; b < 4; b++)
            if (req_wstrb[b]) data_mem[hit_way][idx][off][8*b +: 8] <= req_data[8*b +: 8];
      end
      if (state == REFILL && rvalid) begin
         line_buf[beat] <= D_out;
         if (last_beat) begin
            for (int k = 0; k < LINE_WORDS; k++)
               data_mem[victim][idx][k] <= (k == LINE_WORDS - 1) ? D_out : line_buf[k];
            tag_mem[victim][idx] <= req_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         req_addr   <= '0;
         req_write  <= 1'b0;
         req_wstrb  <= '0;
         req_data   <= '0;
         beat       <= '0;
         victim     <= '0;
         core_out_q <= '0;
         for (int w = 0; w < WAYS; w++) valid[w] <= '0;
         for (int s = 0; s < SETS; s++) ptr[s] <= '0;
`ifdef L1C_PERF_CNT_EN
         perf_hit_cnt  <= '0;
         perf_miss_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (core_req) begin
               req_addr  <= core_addr;
               req_write <= core_write;
               req_wstrb <= core_wstrb;
               req_data  <= core_in;
               state     <= LOOKUP;
            end
            LOOKUP: begin
               if (req_write) begin
                  state <= WRITE;
               end else if (hit) begin
                  core_out_q <= hit_word;
                  state      <= IDLE;
`ifdef L1C_PERF_CNT_EN
                  if (perf_hit_cnt != '1) perf_hit_cnt <= perf_hit_cnt + 32'd1;
`endif
               end else begin
                  victim <= victim_sel;
                  state  <= MREQ;
`ifdef L1C_PERF_CNT_EN
                  if (perf_miss_cnt != '1) perf_miss_cnt <= perf_miss_cnt + 32'd1;
`endif
               end
            end
            WRITE: if (!D_wait) state <= IDLE;
            MREQ: if (!D_wait) begin
               beat  <= '0;
               state <= REFILL;
            end
            REFILL: if (rvalid) begin
               beat <= beat + 1'b1;
               if (last_beat) begin
                  valid[victim][idx] <= 1'b1;
                  ptr[idx]   <= (ptr[idx] == WAY_W'(WAYS - 1)) ? '0 : ptr[idx] + 1'b1;
                  core_out_q <= (off == OFF_W'(LINE_WORDS - 1)) ? D_out : line_buf[off];
                  state      <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1c_data_param.sv
// Directed bench for l1c_data_param (default geometry: 32 sets, 4-word lines, 2 ways).
// Memory side is modelled inline: refill beat k of line base b = ((b ^ 0x100) << 16) | 0x11*(k+1).
module tb_l1c_data_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req = 1'b0;
   logic [31:0] core_addr = '0;
   logic        core_write = 1'b0;
   logic [3:0]  core_wstrb = '0;
   logic [31:0] core_in = '0;
   logic [31:0] core_out;
   logic        core_wait;
   logic        D_req;
   logic [31:0] D_addr;
   logic        D_write;
   logic [31:0] D_in;
   logic [3:0]  D_type;
   logic        D_wait = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] D_out = '0;
`ifdef L1C_PERF_CNT_EN
   logic [31:0] perf_hit_cnt;
   logic [31:0] perf_miss_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   l1c_data_param dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_addr(core_addr), .core_write(core_write),
      .core_wstrb(core_wstrb), .core_in(core_in), .core_out(core_out), .core_wait(core_wait),
      .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in), .D_type(D_type),
      .D_wait(D_wait), .rvalid(rvalid), .D_out(D_out)
`ifdef L1C_PERF_CNT_EN
      , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
   );

   function automatic logic [31:0] beat_dat(input logic [31:0] base, input int k);
      return ((base ^ 32'h100) << 16) | (32'h11 * (k + 1));
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      return beat_dat({a[31:4], 4'h0}, int'(a[3:2]));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic all_zero();
      return ({core_out, core_wait, D_req, D_write, D_addr, D_in, D_type} === '0);
   endfunction

   // waits = cycles with core_wait high after the accept edge; -1 timeout, -2 aborted by reset
   task automatic do_load(input logic [31:0] a, input int abort_at,
                          output logic [31:0] data, output int waits, output logic missed,
                          output logic [31:0] maddr, output logic [3:0] mtype, output logic zero_ok);
      int  beat;
      logic refilling;
      beat = 0; refilling = 1'b0; waits = -1; missed = 1'b0;
      maddr = '0; mtype = '0; data = '0; zero_ok = 1'b0;
      @(negedge clk);
      core_req = 1'b1; core_addr = a; core_write = 1'b0; D_wait = 1'b0;
      @(negedge clk);
      core_req = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         rvalid = 1'b0;
         #1;
         if (!core_wait) begin
            data = core_out; waits = cyc;
            return;
         end
         if (D_req && !D_write) begin
            missed = 1'b1; maddr = D_addr; mtype = D_type; refilling = 1'b1;
         end else if (refilling && beat < 4) begin
            rvalid = 1'b1;
            D_out  = beat_dat({a[31:4], 4'h0}, beat);
            if (beat == abort_at) begin
               rst = 1'b0;
               #1 zero_ok = all_zero();
               @(negedge clk);
               rst = 1'b1; rvalid = 1'b0; waits = -2;
               return;
            end
            beat++;
         end
         @(negedge clk);
      end
      rvalid = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int nwait, output int dreq_cycles, output logic ok);
      ok = 1'b1; dreq_cycles = 0;
      @(negedge clk);
      core_req = 1'b1; core_addr = a; core_write = 1'b1; core_wstrb = s; core_in = d;
      @(negedge clk);
      core_req = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         #1;
         if (D_req) begin
            if (!D_write || D_addr !== a || D_in !== d || D_type !== s) ok = 1'b0;
            D_wait = (dreq_cycles < nwait);
            #1;
            if (core_wait !== D_wait) ok = 1'b0;
            dreq_cycles++;
            if (!core_wait) begin
               D_wait = 1'b0;
               return;
            end
         end else if (cyc > 0) begin
            ok = 1'b0;
         end
         @(negedge clk);
      end
      D_wait = 1'b0;
      ok = 1'b0;
   endtask

   initial begin
      logic [31:0] data, maddr;
      logic [3:0]  mtype;
      logic        missed, zok, sok;
      int          waits, ncyc;

      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs_zero", 64'(all_zero()), 64'd1);
      rst = 1'b1;

      // cold miss: line request, 4 beats, response with word 0
      do_load(32'h100, -1, data, waits, missed, maddr, mtype, zok);
      chk("miss100_missed", 64'(missed), 64'd1);
      chk("miss100_D_addr", 64'(maddr), 64'h100);
      chk("miss100_D_type", 64'(mtype), 64'hF);
      chk("miss100_data", 64'(data), 64'h11);
      chk("miss100_wait_cycles", 64'(waits), 64'd6);

      // hit in same line
      do_load(32'h108, -1, data, waits, missed, maddr, mtype, zok);
      chk("hit108_no_dreq", 64'(missed), 64'd0);
      chk("hit108_wait_cycles", 64'(waits), 64'd0);
      chk("hit108_data", 64'(data), 64'h33);

      // line base of a mid-line miss
      do_load(32'h40C, -1, data, waits, missed, maddr, mtype, zok);
      chk("miss40C_D_addr", 64'(maddr), 64'h400);
      chk("miss40C_data", 64'(data), 64'(exp_word(32'h40C)));
`ifdef L1C_PERF_CNT_EN
      chk("perf_hit_cnt", 64'(perf_hit_cnt), 64'd1);
      chk("perf_miss_cnt", 64'(perf_miss_cnt), 64'd2);
`endif

      // store hit with memory stall, then byte merge visible on reload
      do_store(32'h108, 32'hAABBCCDD, 4'b0011, 3, ncyc, sok);
      chk("st108_fields", 64'(sok), 64'd1);
      chk("st108_dreq_cycles", 64'(ncyc), 64'd4);
      do_load(32'h108, -1, data, waits, missed, maddr, mtype, zok);
      chk("ld108_after_st_hit", 64'(missed), 64'd0);
      chk("ld108_after_st_data", 64'(data), 64'h0000CCDD);

      // store miss: no allocate
      do_store(32'h2000, 32'h12345678, 4'hF, 0, ncyc, sok);
      chk("st2000_fields", 64'(sok), 64'd1);
      chk("st2000_dreq_cycles", 64'(ncyc), 64'd1);
      do_load(32'h2000, -1, data, waits, missed, maddr, mtype, zok);
      chk("ld2000_missed", 64'(missed), 64'd1);
      chk("ld2000_data", 64'(data), 64'(exp_word(32'h2000)));

      // replacement in set 1: A=0x010, B=0x210, C=0x410, D=0x610
      do_load(32'h010, -1, data, waits, missed, maddr, mtype, zok);
      chk("setA_miss", 64'(missed), 64'd1);
      do_load(32'h210, -1, data, waits, missed, maddr, mtype, zok);
      chk("setB_miss", 64'(missed), 64'd1);
      do_load(32'h410, -1, data, waits, missed, maddr, mtype, zok);
      chk("setC_miss", 64'(missed), 64'd1);
      chk("setC_data", 64'(data), 64'(exp_word(32'h410)));
      do_load(32'h214, -1, data, waits, missed, maddr, mtype, zok);
      chk("setB_still_hit", 64'(missed), 64'd0);
      chk("setB_hit_data", 64'(data), 64'(exp_word(32'h214)));
      do_load(32'h610, -1, data, waits, missed, maddr, mtype, zok);
      chk("setD_miss", 64'(missed), 64'd1);
      do_load(32'h418, -1, data, waits, missed, maddr, mtype, zok);
      chk("setC_hit_after_D", 64'(missed), 64'd0);
      chk("setC_hit_data", 64'(data), 64'(exp_word(32'h418)));
      do_load(32'h210, -1, data, waits, missed, maddr, mtype, zok);
      chk("setB_evicted_by_D", 64'(missed), 64'd1);
      do_load(32'h010, -1, data, waits, missed, maddr, mtype, zok);
      chk("setA_evicted_by_C", 64'(missed), 64'd1);

      // reset during second refill beat, then clean refill of the same line
      do_load(32'h804, 1, data, waits, missed, maddr, mtype, zok);
      chk("abort_path_taken", 64'(waits), 64'hFFFF_FFFF_FFFF_FFFE);
      chk("abort_outputs_zero", 64'(zok), 64'd1);
      do_load(32'h804, -1, data, waits, missed, maddr, mtype, zok);
      chk("after_abort_missed", 64'(missed), 64'd1);
      chk("after_abort_wait_cycles", 64'(waits), 64'd6);
      chk("after_abort_data", 64'(data), 64'(exp_word(32'h804)));
      do_load(32'h100, -1, data, waits, missed, maddr, mtype, zok);
      chk("after_abort_valid_cleared", 64'(missed), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
